// File: rtl/zx_io_pkg.sv
// Shared constants, types and helpers for the ULA I/O block.
package zx_io_pkg;

  localparam logic       ULA_PORT_A0    = 1'b0;
  localparam logic [7:0] KEMPSTON_PORT  = 8'h1F;
  localparam int         DEF_INT_PERIOD = 140000;
  localparam int         DEF_INT_LEN    = 64;
  localparam int         DEF_DEB_TICK   = 35000;

  // Registered port-0xFE write state.
  typedef struct packed {
    logic [2:0] border;
    logic       mic;
    logic       beeper;
  } ula_out_t;

  function automatic int key_index(input int row, input int col, input int ncols);
    return row * ncols + col;
  endfunction

endpackage

// File: rtl/zx_key_debounce.sv
// Keyboard matrix input synchroniser and sampled two-vote debouncer.
module zx_key_debounce #(
  parameter int N        = 40,
  parameter int DEB_TICK = 35000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] raw_n,
  output logic [N-1:0] deb
);

  localparam int TW = (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;

  logic [N-1:0]  s1_q, s2_q;
  logic [N-1:0]  prev_q, prev_d;
  logic [N-1:0]  deb_q, deb_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          wrap;

  assign wrap   = (tick_q == TW'(DEB_TICK - 1));
  assign tick_d = wrap ? '0 : tick_q + 1'b1;
  assign prev_d = wrap ? s2_q : prev_q;

  // A key only moves once two consecutive samples agree.
  for (genvar i = 0; i < N; i++) begin : g_key
    assign deb_d[i] = (wrap && (s2_q[i] == prev_q[i])) ? s2_q[i] : deb_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '1;
      s2_q   <= '1;
      prev_q <= '1;
      deb_q  <= '1;
      tick_q <= '0;
    end else begin
      s1_q   <= raw_n;
      s2_q   <= s1_q;
      prev_q <= prev_d;
      deb_q  <= deb_d;
      tick_q <= tick_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/zx_ula_io.sv
// ULA I/O: keyboard/EAR read, border/MIC/beeper write, 50 Hz frame interrupt.
// Optional Kempston joystick port at 0x1F when ZX_IO_KEMPSTON_EN is defined.
module zx_ula_io
  import zx_io_pkg::*;
#(
  parameter int NUM_ROWS   = 8,
  parameter int NUM_COLS   = 5,
  parameter int INT_PERIOD = DEF_INT_PERIOD,
  parameter int INT_LEN    = DEF_INT_LEN,
  parameter int DEB_TICK   = DEF_DEB_TICK
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_ROWS*NUM_COLS-1:0] key_n,
  input  logic                         ear_in,
  input  logic [15:0]                  ad,
  input  logic                         iorq_n,
  input  logic                         rd_n,
  input  logic                         wr_n,
  input  logic [7:0]                   data_in,
`ifdef ZX_IO_KEMPSTON_EN
  input  logic [4:0]                   joy,
`endif
  output logic [7:0]                   data_out,
  output logic                         data_oe,
  output logic                         int_n,
  output logic [2:0]                   border,
  output logic                         mic,
  output logic                         beeper
);

  localparam int NK  = NUM_ROWS * NUM_COLS;
  localparam int FCW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;

  logic [1:0] rst_sync_q;
  logic       rst_n;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [1:0] ear_sync_q;
  logic       ear_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ear_sync_q <= '1;
    else        ear_sync_q <= {ear_sync_q[0], ear_in};
  end
  assign ear_s = ear_sync_q[1];

  logic [NK-1:0] deb;

  zx_key_debounce #(
    .N        (NK),
    .DEB_TICK (DEB_TICK)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .raw_n (key_n),
    .deb   (deb)
  );

  logic sel, rd_sel, wstb;
  assign sel    = !iorq_n && (ad[0] == ULA_PORT_A0);
  assign rd_sel = sel && !rd_n;
  assign wstb   = sel && !wr_n;

`ifdef ZX_IO_KEMPSTON_EN
  logic [1:0][4:0] joy_sync_q;
  logic            joy_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) joy_sync_q <= '1;
    else        joy_sync_q <= {joy_sync_q[0], joy};
  end
  assign joy_rd = !iorq_n && !rd_n && (ad[7:0] == KEMPSTON_PORT);
`endif

  logic [4:0] col;

  // Selected rows are ANDed; unselected rows and absent columns read released.
  always_comb begin
    col = '1;
    for (int c = 0; c < NUM_COLS; c++)
      for (int r = 0; r < NUM_ROWS; r++)
        if (!ad[8+r]) col[c] = col[c] & deb[key_index(r, c, NUM_COLS)];
  end

  always_comb begin
    data_oe  = 1'b0;
    data_out = 8'hFF;
    if (rd_sel) begin
      data_oe  = 1'b1;
      data_out = {1'b1, ear_s, 1'b1, col};
    end
`ifdef ZX_IO_KEMPSTON_EN
    if (joy_rd) begin
      data_oe  = 1'b1;
      data_out = {3'b000, joy_sync_q[1]};
    end
`endif
  end

  // Strobe history resets to "seen" so a strobe spanning reset is not an edge.
  logic     wstb_q;
  ula_out_t out_q, out_d;

  always_comb begin
    out_d = out_q;
    if (wstb && !wstb_q) out_d = '{border: data_in[2:0], mic: data_in[3], beeper: data_in[4]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstb_q <= 1'b1;
      out_q  <= '0;
    end else begin
      wstb_q <= wstb;
      out_q  <= out_d;
    end
  end

  assign border = out_q.border;
  assign mic    = out_q.mic;
  assign beeper = out_q.beeper;

  logic [FCW-1:0] frame_q, frame_d;
  logic           int_n_q, int_n_d;

  always_comb begin
    frame_d = (frame_q == FCW'(INT_PERIOD - 1)) ? '0 : frame_q + 1'b1;
    int_n_d = !(frame_q >= FCW'(INT_PERIOD - INT_LEN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      int_n_q <= 1'b1;
    end else begin
      frame_q <= frame_d;
      int_n_q <= int_n_d;
    end
  end

  assign int_n = int_n_q;

  logic unused_ok;
  assign unused_ok = ^{ad[15:8], ad[7:1], data_in[7:5]};

endmodule

// File: tb/tb_zx_ula_io.sv
// Randomised bench for zx_ula_io with a cycle-level behavioural model.
module tb_zx_ula_io;
  import zx_io_pkg::*;

  localparam int NR = 8, NC = 5, NK = NR * NC;
  localparam int P = 1000, L = 10, D = 12;

  logic          clk = 1'b0, resetn = 1'b0;
  logic [NK-1:0] key_n = '1;
  logic          ear_in = 1'b1;
  logic [15:0]   ad = 16'hFFFF;
  logic          iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0]    data_in = 8'h00;
  logic [7:0]    data_out;
  logic          data_oe, int_n, mic, beeper;
  logic [2:0]    border;
`ifdef ZX_IO_KEMPSTON_EN
  logic [4:0]    joy = 5'h00;
`endif

  always #5 clk = ~clk;

  zx_ula_io #(
    .NUM_ROWS(NR), .NUM_COLS(NC), .INT_PERIOD(P), .INT_LEN(L), .DEB_TICK(D)
  ) dut (
    .clk(clk), .resetn(resetn), .key_n(key_n), .ear_in(ear_in), .ad(ad),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .data_in(data_in),
`ifdef ZX_IO_KEMPSTON_EN
    .joy(joy),
`endif
    .data_out(data_out), .data_oe(data_oe), .int_n(int_n),
    .border(border), .mic(mic), .beeper(beeper)
  );

  int checks = 0, failures = 0;

  // Model: e counts clocks since the internal reset release (2 clocks after resetn rises).
  int            r_cnt = 0, e = 0;
  logic [NK-1:0] key_at1, key_at2, prev_m, deb_m;
  logic          ear_at1, ear_m, wlast;
  logic [4:0]    joy_at1, joy_m;
  logic [2:0]    border_m;
  logic          mic_m, beep_m;
  int            first_fall = -1, low_len = 0;
  logic          rose = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; key_at1 = '1; key_at2 = '1; prev_m = '1; deb_m = '1;
    ear_at1 = 1'b1; ear_m = 1'b1; joy_at1 = '1; joy_m = '1;
    wlast = 1'b1; border_m = '0; mic_m = 1'b0; beep_m = 1'b0;
    first_fall = -1; low_len = 0; rose = 1'b0;
  endtask

  // One clock: advance the model on the edge, compare every output 1 time unit later,
  // return at the falling edge so the caller can drive new inputs.
  task automatic tick();
    logic       ws;
    logic [4:0] col;
    logic [7:0] exp_d;
    logic       exp_oe, exp_int;
    @(posedge clk);
    if (!resetn) begin
      r_cnt = 0;
      model_reset();
    end else begin
      r_cnt++;
      if (r_cnt >= 3) begin
        e = r_cnt - 2;
        // Sample instants every D clocks; the sampled value is the key two clocks ago.
        if (e % D == 0) begin
          for (int i = 0; i < NK; i++)
            if (key_at2[i] == prev_m[i]) deb_m[i] = key_at2[i];
          prev_m = key_at2;
        end
        key_at2 = key_at1; key_at1 = key_n;
        ear_m = ear_at1; ear_at1 = ear_in;
`ifdef ZX_IO_KEMPSTON_EN
        joy_m = joy_at1; joy_at1 = joy;
`endif
        ws = !iorq_n && !ad[0] && !wr_n;
        if (ws && !wlast) begin
          border_m = data_in[2:0]; mic_m = data_in[3]; beep_m = data_in[4];
        end
        wlast = ws;
      end
    end
    #1;
    col = 5'h1F;
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (!ad[8+r]) col[c] = col[c] & deb_m[r*NC+c];
    exp_oe = 1'b0; exp_d = 8'hFF;
    if (!iorq_n && !ad[0] && !rd_n) begin exp_oe = 1'b1; exp_d = {1'b1, ear_m, 1'b1, col}; end
`ifdef ZX_IO_KEMPSTON_EN
    if (!iorq_n && !rd_n && ad[7:0] == 8'h1F) begin exp_oe = 1'b1; exp_d = {3'b000, joy_m}; end
`endif
    exp_int = (resetn && e >= 1 && ((e - 1) % P) >= P - L) ? 1'b0 : 1'b1;
    chk("data_oe", 32'(data_oe), 32'(exp_oe));
    chk("data_out", 32'(data_out), 32'(exp_d));
    chk("int_n", 32'(int_n), 32'(exp_int));
    chk("border", 32'(border), 32'(border_m));
    chk("mic", 32'(mic), 32'(mic_m));
    chk("beeper", 32'(beeper), 32'(beep_m));
    if (resetn && e >= 1) begin
      if (int_n === 1'b0 && first_fall < 0) first_fall = e;
      if (first_fall >= 0 && !rose) begin
        if (int_n === 1'b0) low_len++;
        else rose = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  initial begin
    int idx;
    model_reset();
    repeat (3) tick();
    resetn = 1'b1;
    repeat (3) tick();
    chk("rst_border", 32'(border), 32'd0);
    chk("rst_mic", 32'(mic), 32'd0);
    chk("rst_beeper", 32'(beeper), 32'd0);
    chk("rst_int_n", 32'(int_n), 32'd1);
    chk("rst_oe", 32'(data_oe), 32'd0);
    chk("rst_dout", 32'(data_out), 32'hFF);

    // CAPS SHIFT held long enough to pass debounce.
    key_n[0] = 1'b0;
    repeat (3 * D) tick();
    ad = 16'hFEFE; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("key0_dout", 32'(data_out), 32'hFE);
    chk("key0_oe", 32'(data_oe), 32'd1);
    ad = 16'hFDFE;
    tick();
    chk("row1_cols", 32'(data_out[4:0]), 32'h1F);
    bus_idle(); key_n[0] = 1'b1;
    repeat (3 * D) tick();

    // Bounce: three toggles between consecutive samples, so no two samples agree.
    ad = 16'hFDFE; iorq_n = 1'b0; rd_n = 1'b0;
    for (int t = 0; t < 10 * D; t++) begin
      if (t % (D / 3) == 0) key_n[6] = ~key_n[6];
      tick();
    end
    chk("bounce_key6", 32'(data_out[1]), 32'd1);
    key_n[6] = 1'b1; bus_idle();

    // Two rows selected together.
    key_n[0] = 1'b0; key_n[9] = 1'b0;
    repeat (3 * D) tick();
    ad = 16'hFCFE; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    chk("multirow", 32'(data_out[4:0]), 32'h0E);
    ad = 16'hFFFE;
    tick();
    chk("no_row", 32'(data_out[4:0]), 32'h1F);
    bus_idle(); key_n[0] = 1'b1; key_n[9] = 1'b1;
    repeat (3 * D) tick();

    // OUT (0xFE),0x1A with a held strobe.
    ad = 16'h00FE; data_in = 8'h1A; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("wr_border", 32'(border), 32'h2);
    chk("wr_mic", 32'(mic), 32'd1);
    chk("wr_beeper", 32'(beeper), 32'd1);
    data_in = 8'h05;
    tick(); tick();
    chk("wr_held", 32'(border), 32'h2);
    bus_idle();
    tick();

    // Kempston port read (absent in the default build).
    ad = 16'h001F; iorq_n = 1'b0; rd_n = 1'b0;
`ifdef ZX_IO_KEMPSTON_EN
    joy = 5'b10001;
`endif
    repeat (3) tick();
`ifdef ZX_IO_KEMPSTON_EN
    chk("joy_read", 32'(data_out), 32'h11);
`else
    chk("joy_absent_oe", 32'(data_oe), 32'd0);
`endif
    bus_idle();

    for (int t = 0; t < 1500; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 4))
          0: bus_idle();
          1: begin iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; ad = {8'($urandom), 8'hFE}; end
          2: begin
            iorq_n = 1'b0; rd_n = 1'b1; wr_n = 1'b0;
            ad = {8'($urandom), 7'($urandom), 1'b0}; data_in = 8'($urandom);
          end
          3: begin iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; ad = {8'($urandom), 8'h1F}; end
          default: begin
            iorq_n = 1'($urandom); rd_n = 1'($urandom); wr_n = 1'($urandom);
            ad = 16'($urandom); data_in = 8'($urandom);
          end
        endcase
      end
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, NK - 1);
        key_n[idx] = ~key_n[idx];
      end
      if ($urandom_range(0, 31) == 0) ear_in = ~ear_in;
`ifdef ZX_IO_KEMPSTON_EN
      if ($urandom_range(0, 7) == 0) joy = 5'($urandom);
`endif
      tick();
    end
    bus_idle();
    tick(); tick();

    chk("int_first_fall", 32'(first_fall), 32'd991);
    chk("int_low_len", 32'(low_len), 32'd10);

    // Reset in the middle of a held strobe.
    ad = 16'h00FE; data_in = 8'h05; iorq_n = 1'b0; wr_n = 1'b0;
    tick();
    chk("pre_rst_border", 32'(border), 32'h5);
    resetn = 1'b0;
    #1;
    chk("async_rst_border", 32'(border), 32'h0);
    @(negedge clk);
    tick();
    data_in = 8'h1F; resetn = 1'b1;
    repeat (6) tick();
    chk("post_rst_border", 32'(border), 32'h0);
    chk("post_rst_mic", 32'(mic), 32'd0);
    chk("post_rst_beeper", 32'(beeper), 32'd0);
    bus_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/zx_ula_io.md
Name: zx_ula_io

Overview:
Parametrised ULA I/O port block; successor to the single-button Enter-key port.
- Full 8x5 Spectrum keyboard matrix with debounce.
- Port 0xFE read (keys, EAR) and write (border, MIC, beeper).
- Programmable 50 Hz frame interrupt.
- Sits on the Z80 bus beside the RAM/ROM wrappers, clocked from clk_spectrum. The top level builds the tri-state from data_out/data_oe.

Parameters:
NUM_ROWS, 8, keyboard rows (row r selected by ad[8+r]==0); legal 1..8
NUM_COLS, 5, key columns per row; legal 1..5
INT_PERIOD, 140000, clk cycles per frame (7 MHz / 50 Hz)
INT_LEN, 64, clk cycles int_n held low per frame; must be < INT_PERIOD
DEB_TICK, 35000, clk cycles between debounce samples (5 ms)

Ports:
clk  in  1  block clock (clk_spectrum)
resetn  in  1  asynchronous, active-low reset
key_n  in  NUM_ROWS*NUM_COLS  raw keys, active-low, index = row*NUM_COLS+col, asynchronous
ear_in  in  1  tape input, asynchronous
ad  in  16  CPU address bus
iorq_n  in  1  Z80 IORQ, active-low
rd_n  in  1  Z80 RD, active-low
wr_n  in  1  Z80 WR, active-low
data_in  in  8  CPU data bus (write data)
data_out  out  8  read data
data_oe  out  1  drive data_out onto bus
int_n  out  1  frame interrupt to Z80, active-low
border  out  3  border colour
mic  out  1  MIC output
beeper  out  1  speaker output

Behaviour:
- Reset (resetn low, async): border=0, mic=0, beeper=0, int_n=1, frame counter=0, debounce tick counter=0, all debounced keys released (1), sync flops=1. Release is synchronised internally with a 2-flop reset release.
- Port select: sel = !iorq_n & !ad[0].
- Input sync: key_n and ear_in each pass through 2 flops before use.
- Debounce:
  - Tick counter counts 0..DEB_TICK-1 and wraps.
  - On wrap, each key's synced value is sampled into prev[i].
  - deb[i] updates to the new sample only when it equals prev[i], i.e. two consecutive samples agree.
  - Worst-case press latency is 2*DEB_TICK+3 cycles.
- Read path (combinational from registers):
  - data_oe = sel & !rd_n.
  - data_out = {1, ear_sync, 1, col[4:0]}.
  - col[c] = AND over rows r with ad[8+r]==0 of deb[r*NUM_COLS+c].
  - Columns >= NUM_COLS read 1. No row selected gives all columns 1. Multiple rows selected are ANDed.
  - With sel=0 or rd_n=1: data_oe=0, data_out=8'hFF.
- Write path:
  - wstb = sel & !wr_n, registered once.
  - On the rising edge of wstb (first cycle only): border<=data_in[2:0], mic<=data_in[3], beeper<=data_in[4].
  - A held strobe does not rewrite. Outputs update 1 cycle after the strobe is first seen.
- Simultaneous rd_n and wr_n low: the write is performed and the read is still driven; Z80 never issues this.
- Interrupt:
  - Frame counter counts 0..INT_PERIOD-1 and wraps to 0.
  - int_n is registered: low when counter >= INT_PERIOD-INT_LEN, else high.
  - First falling edge arrives INT_PERIOD-INT_LEN+1 cycles after reset release.
  - int_n is free-running; there is no acknowledge and no CPU access affects it.
- Reset mid-frame or mid-strobe: all state returns to reset values immediately. A strobe still active after release is not treated as a new edge, because the registered wstb resets to 1 (idle = strobe seen) and an edge requires prior 0.

Optional Feature:
ZX_IO_KEMPSTON_EN
- Defined:
  - Adds input port joy[4:0] (active-high: fire, up, down, left, right), 2-flop synced, not debounced.
  - A read with !iorq_n & !rd_n & ad[7:0]==8'h1F sets data_oe=1 and data_out={3'b000, joy_sync}.
  - Port 0x1F has ad[0]=1, so it never overlaps 0xFE.
- Undefined: no joy port; reads of 0x1F leave data_oe=0.

Decomposition:
- Shared package zx_io_pkg:
  - constants ULA_PORT_A0=0, KEMPSTON_PORT=8'h1F, DEF_INT_PERIOD=140000, DEF_INT_LEN=64
  - function key_index(row, col)
- One sub-module zx_key_debounce, parametrised by width N and DEB_TICK: sync, tick counter, prev/deb registers; outputs deb[N-1:0]. The top instantiates it once with N=NUM_ROWS*NUM_COLS.

Test Plan:
- Reset: hold resetn=0, then release -> border=0, mic=0, beeper=0, int_n=1, data_oe=0, data_out=8'hFF.
- Key read: key_n index 0 (row0 col0, CAPS SHIFT) low for 3*DEB_TICK, then read port 16'hFEFE -> data_oe=1, data_out=8'b1x111110. Read 16'hFDFE -> col bits 5'b11111.
- Bounce: toggle key 6 every DEB_TICK/3 cycles for 10*DEB_TICK -> deb[6] stays 1 and reads show no press.
- Multi-row: keys 0 and 9 pressed, read ad=16'hFCFE -> data_out[4:0]=5'b01110. Read 16'hFFFE -> 5'b11111.
- Write: OUT (0xFE),8'h1A with wr_n held 3 cycles -> border=3'b010, mic=1, beeper=1 one cycle after the strobe, no further change. Reset mid-strobe -> outputs return to 0 and are not rewritten after release.
- Interrupt: INT_PERIOD=1000, INT_LEN=10 -> int_n low for exactly 10 cycles every 1000. First fall at cycle 991 after release. With ZX_IO_KEMPSTON_EN, joy=5'b10001 and read ad=16'h001F -> data_out=8'h11.
